// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM encoding for the SPI instruction decoder
// Contents: default bus widths, instruction byte field positions, decoder state type.
package spi_pkg;

  localparam int ADDR_W   = 6;  // register address width
  localparam int DATA_W   = 8;  // byte and register data width

  // Instruction byte: bit7 = write(1)/read(0), bit6 reserved, bits5:0 address.
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for the instruction byte
    DATA = 2'd1,  // waiting for the data (or dummy) byte
    HOLD = 2'd2   // access done, ignore bytes until chip select drops
  } state_t;

endpackage

// File: rtl/spi_instr_decoder_if.sv
// rtl/spi_instr_decoder_if.sv - register access bus between the decoder and the register block
// Signals: read/write strobes, addr, data_write (initiator -> register block),
//          data_read (combinational register block -> initiator).
// Modports: master = decoder (initiator side), slave = register block.
interface spi_instr_decoder_if #(
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DATA_W = spi_pkg::DATA_W
) ();

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;

  modport master (
    output read,
    output write,
    output addr,
    output data_write,
    input  data_read
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_write,
    output data_read
  );

endinterface

// File: rtl/spi_instr_decoder.sv
// rtl/spi_instr_decoder.sv - turns SPI bridge bytes into register-file read/write accesses
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   frame_active    chip select asserted (synchronous to clk)
//   byte_sync       one-cycle pulse, data_in holds a new byte
//   data_in         received byte from the bridge
//   data_out        byte the bridge shifts out next (registered read data)
//   rif (master)    register bus: read, write, addr, data_write out; data_read in
// Build option: define SPI_BURST_EN to keep accessing consecutive addresses
// (wrapping at the top of the address space) for every data-phase byte.
module spi_instr_decoder #(
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DATA_W = spi_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_active,
  input  logic                 byte_sync,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  spi_instr_decoder_if.master  rif
);

  import spi_pkg::*;

  state_t            state, state_d;
  logic              rw, rw_d;
  logic              read_d, write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_write_d;
  logic [DATA_W-1:0] data_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rw             <= 1'b0;
      rif.read       <= 1'b0;
      rif.write      <= 1'b0;
      rif.addr       <= '0;
      rif.data_write <= '0;
      data_out       <= '0;
    end else begin
      state          <= state_d;
      rw             <= rw_d;
      rif.read       <= read_d;
      rif.write      <= write_d;
      rif.addr       <= addr_d;
      rif.data_write <= data_write_d;
      data_out       <= data_out_d;
    end
  end

  always_comb begin
    state_d      = state;
    rw_d         = rw;
    read_d       = 1'b0;
    write_d      = 1'b0;
    addr_d       = rif.addr;
    data_write_d = rif.data_write;
    data_out_d   = data_out;

    // Read data is sampled while the read strobe is on the bus, so it lands
    // in data_out two cycles after the byte that requested it.  An access
    // already on the bus finishes even if the frame ends meanwhile.
    if (rif.read) begin
      data_out_d = rif.data_read;
    end

`ifdef SPI_BURST_EN
    // Step the address once the write has been presented at the old one.
    if (rif.write) begin
      addr_d = rif.addr + 1'b1;
    end
`endif

    if (!frame_active) begin
      state_d = IDLE;
    end else if (byte_sync) begin
      case (state)
        IDLE: begin
          addr_d  = data_in[ADDR_MSB:0];
          rw_d    = data_in[RW_BIT];
          read_d  = !data_in[RW_BIT];
          state_d = DATA;
        end
        DATA: begin
          if (rw) begin
            write_d      = 1'b1;
            data_write_d = data_in;
          end
`ifdef SPI_BURST_EN
          else begin
            // Dummy byte of a read burst: prefetch the next address.
            addr_d = rif.addr + 1'b1;
            read_d = 1'b1;
          end
`else
          state_d = HOLD;
`endif
        end
        default: ;  // HOLD: ignore bytes until chip select drops
      endcase
    end
  end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// tb/tb_spi_instr_decoder.sv - scoreboard bench for spi_instr_decoder with a register block model
module tb_spi_instr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_active = 1'b0;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  spi_instr_decoder_if rif ();

  spi_instr_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .byte_sync    (byte_sync),
    .data_in      (data_in),
    .data_out     (data_out),
    .rif          (rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register block: 64 byte registers, combinational read.
  logic [7:0] regs [64] = '{default: 8'h00};
  assign rif.data_read = regs[rif.addr];
  always @(posedge clk) if (rif.write) regs[rif.addr] <= rif.data_write;

  // Reference view of register contents, updated from the stimulus side.
  logic [7:0] ref_mem [64] = '{default: 8'h00};

  typedef struct {
    bit         w;
    logic [5:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t expq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per strobe and checks data_out one cycle later.
  bit         pend = 0;
  logic [7:0] pend_d;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("data_out", {24'h0, data_out}, {24'h0, pend_d});
        pend = 0;
      end
      if (rif.read || rif.write) begin
        chk("rw_exclusive", {31'h0, rif.read & rif.write}, 32'h0);
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got read=%0b write=%0b addr=%0h expected none",
                   rif.read, rif.write, rif.addr);
        end else begin
          e = expq.pop_front();
          chk("kind", {31'h0, rif.write}, {31'h0, e.w});
          chk("addr", {26'h0, rif.addr}, {26'h0, e.a});
          chk("latency", cyc, e.c);
          if (e.w) chk("data_write", {24'h0, rif.data_write}, {24'h0, e.d});
          else begin
            pend   = 1;
            pend_d = e.d;
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic gap(input int lo, input int hi);
    repeat ($urandom_range(hi, lo)) @(posedge clk);
    #1;
  endtask

  // Drives one byte_sync pulse; returns the cycle in which its strobe should appear.
  task automatic pulse(input logic [7:0] b, output int c);
    @(posedge clk);
    #1;
    data_in   = b;
    byte_sync = 1'b1;
    c         = cyc + 1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    data_in   = $urandom;
  endtask

  task automatic push(input bit w, input logic [5:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.w = w; e.a = a; e.d = d; e.c = c;
    expq.push_back(e);
  endtask

  // One chip-select frame of n bytes; the expected accesses follow from the
  // instruction byte: write/read flag, address, and what each later byte means.
  task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input int n);
    logic [7:0] bb [4];
    int         c;
    logic [5:0] a;
    bit         w;
    bb = '{b0, b1, b2, b3};
    a = 6'h0;
    w = 1'b0;
    frame_active = 1'b1;
    gap(1, 3);
    for (int i = 0; i < n; i++) begin
      pulse(bb[i], c);
      if (i == 0) begin
        a = bb[0][5:0];
        w = bb[0][7];
        if (!w) push(0, a, ref_mem[a], c);
      end else begin
`ifdef SPI_BURST_EN
        if (w) begin
          push(1, a, bb[i], c);
          ref_mem[a] = bb[i];
          a = a + 6'd1;
        end else begin
          a = a + 6'd1;
          push(0, a, ref_mem[a], c);
        end
`else
        if (i == 1 && w) begin
          push(1, a, bb[i], c);
          ref_mem[a] = bb[i];
        end
`endif
      end
      gap(2, 5);
    end
    frame_active = 1'b0;
    gap(3, 3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},       {31'h0, rif.read},        32'h0);
    chk({tag, "_write"},      {31'h0, rif.write},       32'h0);
    chk({tag, "_addr"},       {26'h0, rif.addr},        32'h0);
    chk({tag, "_data_write"}, {24'h0, rif.data_write},  32'h0);
    chk({tag, "_data_out"},   {24'h0, data_out},        32'h0);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    gap(2, 2);

    // Write then read back address 0x00.
    run_frame(8'h80, 8'h34, 8'h00, 8'h00, 2);
    run_frame(8'h00, 8'hFF, 8'h00, 8'h00, 2);
    // Write 0xA5 to 0x0A, read it back with reserved bit set on the read.
    run_frame(8'h8A, 8'hA5, 8'h00, 8'h00, 2);
    run_frame(8'h4A, 8'h00, 8'h00, 8'h00, 2);
    // Abort after the instruction byte, then a complete frame.
    run_frame(8'h82, 8'h00, 8'h00, 8'h00, 1);
    run_frame(8'h82, 8'h01, 8'h00, 8'h00, 2);
    run_frame(8'h02, 8'h00, 8'h00, 8'h00, 2);
    // Extra bytes after the data byte.
    run_frame(8'h83, 8'h10, 8'h20, 8'h00, 3);
    run_frame(8'h03, 8'h00, 8'h00, 8'h00, 2);
    // Top address with continuation bytes (wraps to 0x00 in burst builds).
    run_frame(8'hBF, 8'h11, 8'h22, 8'h00, 3);
    run_frame(8'h3F, 8'h00, 8'h00, 8'h00, 3);

    // Reset while a write strobe is on the bus.
    frame_active = 1'b1;
    gap(1, 2);
    pulse(8'h85, c);
    gap(2, 3);
    pulse(8'h77, c);
    chk("write_inflight", {31'h0, rif.write}, 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    frame_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gap(5, 5);
    run_frame(8'h05, 8'h00, 8'h00, 8'h00, 2);

    // Randomized frames, with stray byte_sync pulses outside frames.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        data_in   = $urandom;
        byte_sync = 1'b1;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        gap(1, 2);
      end
      run_frame($urandom, $urandom, $urandom, $urandom, $urandom_range(4, 1));
    end

    gap(10, 10);
    chk("queue_drained", expq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
